// File: rtl/pcie_dllp_fc_tracker.sv
// PCIe data-link flow-control tracker: DL state machine, InitFC/UpdateFC credit limits and TLP credit grant.
// Optional UpdateFC watchdog is built when PCIE_FC_TIMEOUT_EN is defined.
package pcie_dllp_fc_pkg;
  typedef enum logic [1:0] {
    DL_DOWN   = 2'd0,
    DL_UP     = 2'd1,
    DL_ACTIVE = 2'd2
  } pcie_dl_status_e;
endpackage

module pcie_dllp_fc_tracker
  import pcie_dllp_fc_pkg::*;
#(
  parameter int unsigned FcTimeout = 32'd1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        link_up_i,
  input  logic        dllp_valid_i,
  input  logic [31:0] dllp_i,
  input  logic        tlp_req_valid_i,
  input  logic [1:0]  tlp_req_type_i,
  input  logic [11:0] tlp_req_data_i,
  output logic        tlp_grant_o,
  output logic [1:0]  dl_status_o,
  output logic        fc_timeout_o
);
  localparam int unsigned HdrW     = 8;
  localparam int unsigned DataW    = 12;
  localparam int unsigned NumTypes = 3;
  localparam logic [HdrW-1:0]  HdrWin  = HdrW'(128);
  localparam logic [DataW-1:0] DataWin = DataW'(2048);

  typedef enum logic [1:0] {S_DL_DOWN, S_FC_INIT1, S_FC_INIT2, S_DL_ACTIVE} state_e;

  state_e          r_state, w_state_nxt;
  pcie_dl_status_e r_dl_status, w_dl_status_nxt;

  logic [HdrW-1:0]  r_hdr_cl  [NumTypes];
  logic [HdrW-1:0]  r_hdr_cc  [NumTypes];
  logic [DataW-1:0] r_data_cl [NumTypes];
  logic [DataW-1:0] r_data_cc [NumTypes];
  logic [NumTypes-1:0] r_hdr_inf, r_data_inf, r_rcvd;

  // DLLP decode: FC DLLPs are ccTT_0vvv with cc=01 InitFC1, 11 InitFC2, 10 UpdateFC
  logic [1:0]       w_dllp_t;
  logic [HdrW-1:0]  w_hdrfc;
  logic [DataW-1:0] w_datafc;
  logic             w_fc_vld, w_is_init1, w_is_init2, w_is_update;
  logic             w_unused;

  assign w_dllp_t    = dllp_i[5:4];
  assign w_hdrfc     = {dllp_i[13:8], dllp_i[23:22]};
  assign w_datafc    = {dllp_i[19:16], dllp_i[31:24]};
  assign w_fc_vld    = dllp_valid_i && !dllp_i[3] && (dllp_i[2:0] == 3'd0) &&
                       (w_dllp_t != 2'd3) && (dllp_i[7:6] != 2'b00);
  assign w_is_init1  = w_fc_vld && (dllp_i[7:6] == 2'b01);
  assign w_is_init2  = w_fc_vld && (dllp_i[7:6] == 2'b11);
  assign w_is_update = w_fc_vld && (dllp_i[7:6] == 2'b10);

  // Credit check against pre-update limits; modular windows handle counter wrap
  logic [1:0]       w_req_idx;
  logic [HdrW-1:0]  w_hdr_room;
  logic [DataW-1:0] w_data_room;
  logic             w_hdr_ok, w_data_ok;

  assign w_req_idx   = (tlp_req_type_i == 2'd3) ? 2'd0 : tlp_req_type_i;
  assign w_hdr_room  = HdrW'(r_hdr_cl[w_req_idx] - r_hdr_cc[w_req_idx] - HdrW'(1));
  assign w_data_room = DataW'(r_data_cl[w_req_idx] - r_data_cc[w_req_idx] - tlp_req_data_i);
  assign w_hdr_ok    = r_hdr_inf[w_req_idx] || (w_hdr_room <= HdrWin);
  assign w_data_ok   = r_data_inf[w_req_idx] || (w_data_room <= DataWin);
  assign tlp_grant_o = (r_state == S_DL_ACTIVE) && tlp_req_valid_i &&
                       (tlp_req_type_i != 2'd3) && w_hdr_ok && w_data_ok;

  always_comb begin
    w_state_nxt     = r_state;
    w_dl_status_nxt = DL_DOWN;
    case (r_state)
      S_DL_DOWN:   if (link_up_i) w_state_nxt = S_FC_INIT1;
      S_FC_INIT1:  if (&r_rcvd) w_state_nxt = S_FC_INIT2;
      S_FC_INIT2:  if (w_is_init2 || w_is_update) w_state_nxt = S_DL_ACTIVE;
      S_DL_ACTIVE: w_state_nxt = S_DL_ACTIVE;
      default:     w_state_nxt = S_DL_DOWN;
    endcase
    if (!link_up_i) w_state_nxt = S_DL_DOWN;
    case (w_state_nxt)
      S_FC_INIT1, S_FC_INIT2: w_dl_status_nxt = DL_UP;
      S_DL_ACTIVE:            w_dl_status_nxt = DL_ACTIVE;
      default:                w_dl_status_nxt = DL_DOWN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_DL_DOWN;
      r_dl_status <= DL_DOWN;
    end else begin
      r_state     <= w_state_nxt;
      r_dl_status <= w_dl_status_nxt;
    end
  end

  assign dl_status_o = r_dl_status;

  // Limits, consumed counters and flags; link loss wipes everything
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hdr_inf  <= '0;
      r_data_inf <= '0;
      r_rcvd     <= '0;
      for (int i = 0; i < NumTypes; i++) begin
        r_hdr_cl[i]  <= '0;
        r_hdr_cc[i]  <= '0;
        r_data_cl[i] <= '0;
        r_data_cc[i] <= '0;
      end
    end else if (!link_up_i) begin
      r_hdr_inf  <= '0;
      r_data_inf <= '0;
      r_rcvd     <= '0;
      for (int i = 0; i < NumTypes; i++) begin
        r_hdr_cl[i]  <= '0;
        r_hdr_cc[i]  <= '0;
        r_data_cl[i] <= '0;
        r_data_cc[i] <= '0;
      end
    end else begin
      if ((r_state == S_FC_INIT1) && w_is_init1) begin
        r_hdr_cl[w_dllp_t]   <= w_hdrfc;
        r_data_cl[w_dllp_t]  <= w_datafc;
        r_hdr_inf[w_dllp_t]  <= (w_hdrfc == '0);
        r_data_inf[w_dllp_t] <= (w_datafc == '0);
        r_rcvd[w_dllp_t]     <= 1'b1;
      end
      if ((r_state == S_DL_ACTIVE) && w_is_update) begin
        if (!r_hdr_inf[w_dllp_t])  r_hdr_cl[w_dllp_t]  <= w_hdrfc;
        if (!r_data_inf[w_dllp_t]) r_data_cl[w_dllp_t] <= w_datafc;
      end
      if (tlp_grant_o) begin
        r_hdr_cc[w_req_idx]  <= HdrW'(r_hdr_cc[w_req_idx] + HdrW'(1));
        r_data_cc[w_req_idx] <= DataW'(r_data_cc[w_req_idx] + tlp_req_data_i);
      end
    end
  end

`ifdef PCIE_FC_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_fc_timeout;

  // Watchdog: counts DL_ACTIVE cycles since the last VC0 UpdateFC; flag is sticky
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt     <= '0;
      r_fc_timeout <= 1'b0;
    end else if (!link_up_i) begin
      r_to_cnt     <= '0;
      r_fc_timeout <= 1'b0;
    end else if (w_is_update) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_DL_ACTIVE) && !r_fc_timeout) begin
      r_to_cnt <= r_to_cnt + 32'd1;
      if ((r_to_cnt + 32'd1) == 32'(FcTimeout)) r_fc_timeout <= 1'b1;
    end
  end

  assign fc_timeout_o = r_fc_timeout;
  assign w_unused     = ^dllp_i[21:20];
`else
  assign fc_timeout_o = 1'b0;
  assign w_unused     = ^{dllp_i[21:20], 32'(FcTimeout)};
`endif

endmodule

// File: tb/tb_pcie_dllp_fc_tracker.sv
// Directed self-checking bench for pcie_dllp_fc_tracker (FcTimeout = 1000).
// Expects fc_timeout_o to assert only when PCIE_FC_TIMEOUT_EN is defined.
module tb_pcie_dllp_fc_tracker;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        link_up_i;
  logic        dllp_valid_i;
  logic [31:0] dllp_i;
  logic        tlp_req_valid_i;
  logic [1:0]  tlp_req_type_i;
  logic [11:0] tlp_req_data_i;
  logic        tlp_grant_o;
  logic [1:0]  dl_status_o;
  logic        fc_timeout_o;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [1:0] StDown   = 2'd0;
  localparam logic [1:0] StUp     = 2'd1;
  localparam logic [1:0] StActive = 2'd2;
`ifdef PCIE_FC_TIMEOUT_EN
  localparam logic TimeoutExp = 1'b1;
`else
  localparam logic TimeoutExp = 1'b0;
`endif

  pcie_dllp_fc_tracker #(.FcTimeout(1000)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .link_up_i       (link_up_i),
    .dllp_valid_i    (dllp_valid_i),
    .dllp_i          (dllp_i),
    .tlp_req_valid_i (tlp_req_valid_i),
    .tlp_req_type_i  (tlp_req_type_i),
    .tlp_req_data_i  (tlp_req_data_i),
    .tlp_grant_o     (tlp_grant_o),
    .dl_status_o     (dl_status_o),
    .fc_timeout_o    (fc_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_dllp(input logic [3:0] cls, input logic [2:0] vc,
                                          input logic [7:0] hdr, input logic [11:0] data);
    logic [31:0] d;
    d        = '0;
    d[7:4]   = cls;
    d[2:0]   = vc;
    d[13:8]  = hdr[7:2];
    d[23:22] = hdr[1:0];
    d[19:16] = data[11:8];
    d[31:24] = data[7:0];
    return d;
  endfunction

  // All stimulus changes and samples happen around the falling edge
  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send(input logic [31:0] d);
    dllp_valid_i = 1'b1;
    dllp_i       = d;
    cyc();
    dllp_valid_i = 1'b0;
    dllp_i       = '0;
  endtask

  task automatic req(input logic [1:0] t, input logic [11:0] d);
    tlp_req_valid_i = 1'b1;
    tlp_req_type_i  = t;
    tlp_req_data_i  = d;
    #1;
  endtask

  initial begin
    int grants;
    rst_ni          = 1'b0;
    link_up_i       = 1'b0;
    dllp_valid_i    = 1'b0;
    dllp_i          = '0;
    tlp_req_valid_i = 1'b1;
    tlp_req_type_i  = 2'd2;
    tlp_req_data_i  = 12'd0;

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_status", 32'(dl_status_o), 32'(StDown));
    chk("rst_grant", 32'(tlp_grant_o), 0);
    chk("rst_timeout", 32'(fc_timeout_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
    chk("down_status", 32'(dl_status_o), 32'(StDown));

    // Init handshake
    link_up_i = 1'b1;
    cyc();
    chk("init1_status", 32'(dl_status_o), 32'(StUp));
    req(2'd2, 12'd0);
    chk("init1_no_grant", 32'(tlp_grant_o), 0);
    tlp_req_valid_i = 1'b0;
    send(mk_dllp(4'h4, 3'd0, 8'd8, 12'd64));
    send(mk_dllp(4'h5, 3'd0, 8'd1, 12'd16));
    send(mk_dllp(4'h6, 3'd0, 8'd0, 12'd0));
    cyc();
    chk("init2_status", 32'(dl_status_o), 32'(StUp));
    send(mk_dllp(4'hC, 3'd1, 8'd0, 12'd0));
    send(32'h0000_0000);
    chk("init2_ignore_vc1_ack", 32'(dl_status_o), 32'(StUp));
    send(mk_dllp(4'h8, 3'd0, 8'd3, 12'd3));
    chk("active_status", 32'(dl_status_o), 32'(StActive));

    // Cpl is infinite in both fields; type 3 is never granted
    req(2'd2, 12'd4095);
    chk("cpl_inf_grant0", 32'(tlp_grant_o), 1);
    cyc();
    req(2'd2, 12'd4095);
    chk("cpl_inf_grant1", 32'(tlp_grant_o), 1);
    cyc();
    req(2'd3, 12'd0);
    chk("type3_refused", 32'(tlp_grant_o), 0);

    // P exhaustion with CL 8/64
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      req(2'd0, 12'd8);
      if (tlp_grant_o === 1'b1) grants++;
      cyc();
    end
    chk("p_exh_8_grants", 32'(grants), 8);
    req(2'd0, 12'd8);
    chk("p_exh_9th", 32'(tlp_grant_o), 0);
    dllp_valid_i = 1'b1;
    dllp_i       = mk_dllp(4'h8, 3'd0, 8'd16, 12'd128);
    #1;
    chk("p_upd_pre_limit", 32'(tlp_grant_o), 0);
    cyc();
    dllp_valid_i = 1'b0;
    dllp_i       = '0;
    #1;
    chk("p_upd_granted", 32'(tlp_grant_o), 1);
    cyc();

    // Header counter wrap: CC_hdr 9 -> 255 with limits kept ahead
    grants = 0;
    for (int k = 0; k < 246; k++) begin
      dllp_valid_i = 1'b1;
      dllp_i       = mk_dllp(4'h8, 3'd0, 8'(9 + k + 1 + 64), 12'd128);
      req(2'd0, 12'd0);
      if (tlp_grant_o === 1'b1) grants++;
      cyc();
    end
    dllp_valid_i    = 1'b0;
    tlp_req_valid_i = 1'b0;
    chk("wrap_ramp_grants", 32'(grants), 246);
    send(mk_dllp(4'h8, 3'd0, 8'd2, 12'd128));
    req(2'd0, 12'd0);
    chk("wrap_cc255", 32'(tlp_grant_o), 1);
    cyc();
    req(2'd0, 12'd0);
    chk("wrap_cc0", 32'(tlp_grant_o), 1);
    cyc();
    req(2'd0, 12'd0);
    chk("wrap_cc1", 32'(tlp_grant_o), 1);
    cyc();
    req(2'd0, 12'd0);
    chk("wrap_cc2_refused", 32'(tlp_grant_o), 0);

    // Simultaneous UpdateFC_NP(5,40) with NP grant of 4 (CL 1/16, CC 0/0)
    dllp_valid_i = 1'b1;
    dllp_i       = mk_dllp(4'h9, 3'd0, 8'd5, 12'd40);
    req(2'd1, 12'd4);
    chk("sim_grant", 32'(tlp_grant_o), 1);
    cyc();
    dllp_valid_i = 1'b0;
    dllp_i       = '0;
    req(2'd1, 12'd37);
    chk("sim_np_37_refused", 32'(tlp_grant_o), 0);
    req(2'd1, 12'd36);
    chk("sim_np_36_granted", 32'(tlp_grant_o), 1);
    cyc();
    req(2'd1, 12'd1);
    chk("np_data1_refused", 32'(tlp_grant_o), 0);
    req(2'd1, 12'd0);
    chk("np_data0_hdr_only", 32'(tlp_grant_o), 1);
    tlp_req_valid_i = 1'b0;
    cyc();

    // Update watchdog
    chk("to_early", 32'(fc_timeout_o), 0);
    repeat (1000) cyc();
    chk("to_after_1000", 32'(fc_timeout_o), 32'(TimeoutExp));
    send(mk_dllp(4'hA, 3'd0, 8'd4, 12'd4));
    chk("to_sticky", 32'(fc_timeout_o), 32'(TimeoutExp));
    req(2'd2, 12'd100);
    chk("to_no_gate", 32'(tlp_grant_o), 1);

    // Link drop mid-traffic
    link_up_i = 1'b0;
    cyc();
    chk("drop_status", 32'(dl_status_o), 32'(StDown));
    chk("drop_grant", 32'(tlp_grant_o), 0);
    chk("drop_timeout", 32'(fc_timeout_o), 0);
    link_up_i = 1'b1;
    cyc();
    chk("relink_status", 32'(dl_status_o), 32'(StUp));
    chk("relink_grant", 32'(tlp_grant_o), 0);
    send(mk_dllp(4'h8, 3'd0, 8'd8, 12'd8));
    send(mk_dllp(4'h8, 3'd0, 8'd8, 12'd8));
    chk("relink_needs_init", 32'(dl_status_o), 32'(StUp));

    // Asynchronous reset inside FC_INIT1
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_status", 32'(dl_status_o), 32'(StDown));
    chk("arst_grant", 32'(tlp_grant_o), 0);
    chk("arst_timeout", 32'(fc_timeout_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
